// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path, including the scope acquisition front end.
package vga_pkg;

    localparam int SCOPE_N_SAMPLES = 256;
    localparam int SCOPE_DATA_W    = 12;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        HOLD      = 2'd3
    } scope_state_t;

endpackage

// File: rtl/scope_capture_trigger_detect.sv
// Level/slope trigger with auto-mode timeout; evaluates one ADC sample per valid strobe.
module trigger_detect #(
    parameter int DATA_W       = 12,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              load_i,
    input  logic              eval_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              slope_i,
    input  logic              auto_i,
    output logic              trig_o
);

    localparam int                CNT_W = $clog2(AUTO_TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(AUTO_TIMEOUT - 1);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rise_s, fall_s, force_s;

    // Crossing compare against the previous sample, plus next-state for prev/timeout.
    always_comb begin
        rise_s  = (prev_q < level_i) && (sample_i >= level_i);
        fall_s  = (prev_q > level_i) && (sample_i <= level_i);
        force_s = auto_i && (cnt_q == LAST);
        trig_o  = valid_i && eval_i && ((slope_i ? fall_s : rise_s) || force_s);
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        if (valid_i && load_i) begin
            prev_d = sample_i;
            cnt_d  = '0;
        end else if (valid_i && eval_i && !trig_o) begin
            prev_d = sample_i;
            cnt_d  = (cnt_q == LAST) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            prev_d = prev_q;
        end
    end

    // Previous-sample and timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/scope_capture.sv
// Scope acquisition: trigger, capture a frame into a register buffer, publish it on vblank rise.
module scope_capture
    import vga_pkg::*;
#(
    parameter int N_SAMPLES    = SCOPE_N_SAMPLES,
    parameter int DATA_W       = SCOPE_DATA_W,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              trig_auto,
    input  logic              run,
    input  logic              vblnk,
    output logic [DATA_W-1:0] data_display [0:N_SAMPLES-1],
    output logic              frame_ready,
    output logic              triggered
);

    localparam int               IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_SAMPLES - 1);

    scope_state_t      state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] buf_q [0:N_SAMPLES-1];
    logic              vblnk_q;
    logic              frozen_q;
    logic              trig_s;

    trigger_detect #(
        .DATA_W       (DATA_W),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trig (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (adc_valid),
        .sample_i (adc_data),
        .load_i   (state_q == ARM),
        .eval_i   (state_q == WAIT_TRIG),
        .level_i  (trig_level),
        .slope_i  (trig_slope),
        .auto_i   (trig_auto),
        .trig_o   (trig_s)
    );

    // Acquisition FSM with capture buffer and registered publish outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARM;
            idx_q       <= '0;
            vblnk_q     <= 1'b0;
            frozen_q    <= 1'b0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                buf_q[i]        <= '0;
                data_display[i] <= '0;
            end
        end else begin
            vblnk_q     <= vblnk;
            frame_ready <= 1'b0;
            case (state_q)
                ARM: begin
                    if (adc_valid) state_q <= WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (trig_s) begin
                        buf_q[0]  <= adc_data;
                        idx_q     <= IDX_W'(1);
                        triggered <= 1'b1;
                        state_q   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        buf_q[idx_q] <= adc_data;
                        idx_q        <= idx_q + IDX_W'(1);
                        if (idx_q == LAST) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Once frozen, only run brings us back; the frame is never republished.
                    if (frozen_q) begin
                        if (run) begin
                            frozen_q <= 1'b0;
                            state_q  <= ARM;
                        end
                    end else if (vblnk && !vblnk_q) begin
                        data_display <= buf_q;
                        frame_ready  <= 1'b1;
                        triggered    <= 1'b0;
                        if (run) state_q <= ARM;
                        else     frozen_q <= 1'b1;
                    end
                end
                default: state_q <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_scope_capture.sv
// Directed self-checking bench for scope_capture.
module tb_scope_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [11:0] trig_level;
    logic        trig_slope;
    logic        trig_auto;
    logic        run;
    logic        vblnk;
    logic [11:0] disp [0:255];
    logic        frame_ready;
    logic        triggered;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scope_capture dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .trig_auto    (trig_auto),
        .run          (run),
        .vblnk        (vblnk),
        .data_display (disp),
        .frame_ready  (frame_ready),
        .triggered    (triggered)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, input int gap);
        @(negedge clk);
        adc_data  = d;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic vpulse(input logic exp_fr);
        @(negedge clk);
        vblnk = 1'b1;
        @(negedge clk);
        chk("vblank_frame_ready", 32'(frame_ready), 32'(exp_fr));
        @(negedge clk);
        chk("frame_ready_width", 32'(frame_ready), 32'd0);
        vblnk = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        adc_data   = 12'h000;
        adc_valid  = 1'b0;
        trig_level = 12'h800;
        trig_slope = 1'b0;
        trig_auto  = 1'b0;
        run        = 1'b1;
        vblnk      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_frame_ready", 32'(frame_ready), 32'd0);
        chk("reset_triggered", 32'(triggered), 32'd0);
        chk("reset_disp0", 32'(disp[0]), 32'h000);
        chk("reset_disp255", 32'(disp[255]), 32'h000);
        rst = 1'b0;

        // Rising trigger on a ramp, one valid every 4 clocks
        for (int i = 0; i < 128; i++) send(12'(i * 16), 2);
        chk("rise_not_yet", 32'(triggered), 32'd0);
        send(12'h800, 2);
        chk("rise_triggered", 32'(triggered), 32'd1);
        for (int i = 129; i < 384; i++) send(12'(i * 16), 2);
        repeat (4) @(negedge clk);
        chk("rise_no_publish_yet", 32'(disp[0]), 32'h000);
        chk("rise_no_frame_ready", 32'(frame_ready), 32'd0);
        vpulse(1'b1);
        chk("rise_disp0", 32'(disp[0]), 32'h800);
        chk("rise_disp1", 32'(disp[1]), 32'h810);
        chk("rise_disp127", 32'(disp[127]), 32'hFF0);
        chk("rise_disp128_wrap", 32'(disp[128]), 32'h000);
        chk("rise_disp255", 32'(disp[255]), 32'h7F0);
        chk("rise_trig_cleared", 32'(triggered), 32'd0);

        // Falling trigger; equal-to-level without crossing must not fire
        trig_slope = 1'b1;
        send(12'h800, 0);
        send(12'h800, 0);
        chk("fall_equal_no_trig", 32'(triggered), 32'd0);
        send(12'h900, 0);
        send(12'h900, 0);
        chk("fall_above_no_trig", 32'(triggered), 32'd0);
        send(12'h700, 0);
        chk("fall_triggered", 32'(triggered), 32'd1);
        for (int k = 1; k < 255; k++) send(12'(k), 0);
        @(negedge clk);
        vblnk = 1'b1;
        send(12'h0FF, 0);
        repeat (3) @(negedge clk);
        chk("vbl_high_no_publish", 32'(frame_ready), 32'd0);
        chk("vbl_high_disp_old", 32'(disp[0]), 32'h800);
        vblnk = 1'b0;
        @(negedge clk);
        vpulse(1'b1);
        chk("fall_disp0", 32'(disp[0]), 32'h700);
        chk("fall_disp7", 32'(disp[7]), 32'h007);
        chk("fall_disp255", 32'(disp[255]), 32'h0FF);

        // Freeze: run dropped during capture
        trig_slope = 1'b0;
        send(12'h000, 0);
        send(12'h900, 0);
        run = 1'b0;
        for (int k = 1; k < 256; k++) send(12'h0AA, 0);
        vpulse(1'b1);
        chk("frz_disp0", 32'(disp[0]), 32'h900);
        chk("frz_disp1", 32'(disp[1]), 32'h0AA);
        send(12'h000, 0);
        send(12'hFFF, 0);
        for (int v = 0; v < 3; v++) begin
            vpulse(1'b0);
            chk("frz_disp0_stable", 32'(disp[0]), 32'h900);
            chk("frz_trig_low", 32'(triggered), 32'd0);
        end
        run = 1'b1;
        @(negedge clk);
        send(12'h900, 0);
        chk("resume_arm_no_trig", 32'(triggered), 32'd0);
        send(12'h000, 0);
        send(12'h900, 0);
        chk("resume_triggered", 32'(triggered), 32'd1);

        // Async reset at idx=100 of a capture
        for (int k = 1; k < 100; k++) send(12'h055, 0);
        chk("pre_rst_triggered", 32'(triggered), 32'd1);
        chk("pre_rst_disp0", 32'(disp[0]), 32'h900);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_triggered", 32'(triggered), 32'd0);
        chk("async_rst_disp0", 32'(disp[0]), 32'h000);
        chk("async_rst_disp1", 32'(disp[1]), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        send(12'h900, 0);
        chk("post_rst_arm", 32'(triggered), 32'd0);
        send(12'h000, 0);
        send(12'h900, 0);
        chk("post_rst_trig", 32'(triggered), 32'd1);

        // Auto timeout: one ARM sample plus 4096 evaluated samples
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        trig_auto = 1'b1;
        for (int k = 0; k < 4096; k++) send(12'h100, 0);
        chk("auto_not_yet", 32'(triggered), 32'd0);
        send(12'h100, 0);
        chk("auto_triggered", 32'(triggered), 32'd1);
        for (int k = 1; k < 256; k++) send(12'h100, 0);
        vpulse(1'b1);
        chk("auto_disp0", 32'(disp[0]), 32'h100);
        chk("auto_disp128", 32'(disp[128]), 32'h100);
        chk("auto_disp255", 32'(disp[255]), 32'h100);

        // Normal mode never forces a trigger
        trig_auto = 1'b0;
        for (int k = 0; k < 5000; k++) send(12'h100, 0);
        chk("normal_no_trig", 32'(triggered), 32'd0);
        send(12'h900, 0);
        chk("normal_cross_trig", 32'(triggered), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scope_capture.md
# scope_capture

Acquisition front end of the oscilloscope: takes the ADC sample stream, waits for a level/slope trigger, and captures 256 consecutive 12-bit samples into an internal buffer. It then publishes that frame to the `data_display` array consumed by the display drawing stage. Publication happens only on the rising edge of vertical blanking, so the trace never tears mid-frame.

## Interface
Parameters:
- `N_SAMPLES`, 256: frame length. Must be a power of two.
- `DATA_W`, 12: sample width.
- `AUTO_TIMEOUT`, 4096: accepted samples in `WAIT_TRIG` before auto mode forces a trigger.

Ports:
- `clk` in 1: system/pixel clock. The single clock domain.
- `rst` in 1: reset. Asynchronous, active-high.
- `adc_data` in DATA_W: unsigned ADC sample.
- `adc_valid` in 1: single-cycle strobe; `adc_data` is valid this cycle.
- `trig_level` in DATA_W: trigger threshold, unsigned.
- `trig_slope` in 1: 0 = rising, 1 = falling.
- `trig_auto` in 1: 1 = auto mode (forced trigger on timeout), 0 = normal mode.
- `run` in 1: 1 = acquire continuously; 0 = freeze after the current frame is published.
- `vblnk` in 1: vertical blanking from VGA timing, synchronous to `clk`.
- `data_display` out DATA_W × [0:N_SAMPLES-1]: published frame.
- `frame_ready` out 1: one-cycle pulse on the cycle `data_display` updates.
- `triggered` out 1: high from trigger detection until publication.

## Operation
- State machine states: `ARM`, `WAIT_TRIG`, `CAPTURE`, `HOLD`.
- `ARM`:
  - Waits for the first `adc_valid` and latches that sample as `prev`.
  - Goes to `WAIT_TRIG` and clears the timeout counter.
  - Purpose: no trigger can fire on a stale `prev`.
- `WAIT_TRIG`, evaluated only on each `adc_valid`:
  - Rising trigger: `prev < trig_level && adc_data >= trig_level`.
  - Falling trigger: `prev > trig_level && adc_data <= trig_level`.
  - Forced trigger: `trig_auto` high and the timeout counter equals `AUTO_TIMEOUT-1`.
  - On any trigger, the triggering sample is written to `buf[0]`, the write index becomes 1, and the state goes to `CAPTURE`.
  - Otherwise `prev <= adc_data` and the timeout counter increments.
  - In normal mode the timeout counter saturates.
- `CAPTURE`:
  - Each `adc_valid` writes `buf[idx]` and increments `idx`. `idx` is log2(N_SAMPLES) bits.
  - After the write at `idx == N_SAMPLES-1`, go to `HOLD`.
  - `idx` wraps to 0 there; no overflow write occurs.
- `HOLD`:
  - Waits for the `vblnk` rising edge (`vblnk && !vblnk_d`).
  - On that edge: `data_display <= buf` (all entries in one cycle), `frame_ready` pulses, `triggered` clears.
  - Next state is `ARM` if `run` is high, otherwise stay in `HOLD` with publishing disabled.
  - While frozen, a later `run` high returns to `ARM` on the next cycle, with no republish.
- `adc_valid` during `HOLD` or the frozen state: samples are dropped.
- Comparisons are unsigned and `DATA_W` wide; no arithmetic widening is needed.
- Trigger parameter changes (`trig_level`, `trig_slope`, `trig_auto`) take effect on the next evaluated sample.

## Timing
- Reset values:
  - State `ARM`; `idx`, `prev` and the timeout counter = 0.
  - `buf` and `data_display` entries all 0.
  - `frame_ready` = 0, `triggered` = 0, `vblnk_d` = 0.
- `triggered` rises the cycle after the triggering `adc_valid`.
- Capture latency: N_SAMPLES valid strobes, counting the triggering sample.
- Publish latency: `frame_ready` and the new `data_display` are both visible 1 cycle after the `vblnk` rising edge.
- `vblnk` already high when `HOLD` is entered does not count as an edge; the block waits for the next blanking period.
- `rst` asserted mid-capture: everything clears immediately, including `data_display`.
- `adc_valid` and a `vblnk` edge in the same cycle: they do not conflict, because the states are exclusive.

## Structure
- Shared package `vga_pkg` gains:
  - `SCOPE_N_SAMPLES = 256`, `SCOPE_DATA_W = 12`.
  - typedef `scope_state_t` enum.
- One sub-module, `trigger_detect`: registered `prev`, slope compare, auto-timeout counter, `trig` output. It is reused by a future DFT capture path.
- `buf` is a register array, not BRAM, because `data_display` is a full parallel array.

## Test plan
- Rising trigger:
  - Stimulus: `trig_level=0x800`, rising slope, normal mode; a ramp 0x000→0xFFF in steps of 0x10, one `adc_valid` per 4 clocks.
  - Expected: `buf[0]=0x800` and `buf[255]=0x17F0`; 12-bit wrap gives `0x7F0`.
  - Expected: `data_display` updates only after the next `vblnk` rise.
- Falling trigger:
  - Stimulus: samples 0x900, 0x900, 0x700.
  - Expected: triggers on 0x700, so `data_display[0]=0x700`.
  - Expected: equal-to-level with no crossing does not trigger.
- Auto timeout:
  - Stimulus: constant 0x100, `trig_auto=1`, level 0x800.
  - Expected: `triggered` rises after exactly 4096 valids and the frame is all 0x100.
  - With `trig_auto=0`: no trigger ever.
- Vblank gating:
  - Stimulus: `vblnk` already high on entering `HOLD`.
  - Expected: no publish until `vblnk` falls and rises again; `frame_ready` is exactly 1 cycle wide.
- Freeze:
  - Stimulus: `run=0` during capture.
  - Expected: one publish, then `data_display` stays stable across 3 further vblanks; `run=1` resumes with `ARM`.
- Async reset mid-`CAPTURE` at `idx=100`:
  - Expected: outputs zero without a clock edge.
  - Expected: the next frame restarts from `ARM`.
